reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release for three downstream blocks, gated by PLL lock.
// Each stage is released in order, waits for its ready, then a fixed gap.
module reset_sequencer #(
   parameter int LOCK_CYCLES = 8,
   parameter int GAP_CYCLES  = 16,
   parameter int TIMEOUT     = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic [2:0] ready_i,
   output logic [2:0] reset_o,
   output logic       done_o,
   output logic       error_o,
   output logic [2:0] state_o,
   output logic [1:0] stage_o
);

   localparam int MAX_AB = (LOCK_CYCLES > GAP_CYCLES) ? LOCK_CYCLES : GAP_CYCLES;
   localparam int MAX_C  = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
   localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      WAIT_READY = 3'd1,
      GAP        = 3'd2,
      RUN        = 3'd3,
      FAULT      = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    stage_q, stage_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    rst_q, rst_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          lock_m, lock_s;
   logic          rdy;
   logic          lost;

   // Two-flop synchroniser for the asynchronous lock input.
   always_ff @(posedge clock) begin
      if (reset) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;
      end
   end

   // State and output registers; reset overrides everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= WAIT_LOCK;
         stage_q <= 2'd0;
         cnt_q   <= '0;
         rst_q   <= 3'b111;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; lock loss beats ready and timeout.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      done_d  = done_q;
      err_d   = err_q;
      rdy     = |(ready_i & ~rst_q & (3'b001 << stage_q));
      lost    = !lock_s && (state_q == WAIT_READY ||
                            state_q == GAP ||
                            state_q == RUN);
      if (lost) begin
         state_d = WAIT_LOCK;
         stage_d = 2'd0;
         cnt_d   = '0;
         rst_d   = 3'b111;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt_d = '0;
               end else if (cnt_q == LOCK_LAST) begin
                  rst_d   = 3'b110;
                  stage_d = 2'd0;
                  cnt_d   = '0;
                  state_d = WAIT_READY;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            WAIT_READY: begin
               if (rdy) begin
                  cnt_d = '0;
                  if (stage_q == 2'd2) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = GAP;
                  end
               end else if (cnt_q == TO_LAST) begin
                  state_d = FAULT;
                  err_d   = 1'b1;
                  rst_d   = 3'b111;
                  done_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  rst_d   = {rst_q[1:0], 1'b0};
                  stage_d = stage_q + 2'd1;
                  cnt_d   = '0;
                  state_d = WAIT_READY;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            RUN: begin
               done_d = 1'b1;
            end
            FAULT: begin
               err_d  = 1'b1;
               rst_d  = 3'b111;
               done_d = 1'b0;
            end
            default: begin
               state_d = WAIT_LOCK;
               stage_d = 2'd0;
               cnt_d   = '0;
               rst_d   = 3'b111;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         endcase
      end
   end

   assign reset_o = rst_q;
   assign done_o  = done_q;
   assign error_o = err_q;
   assign state_o = state_q;
   assign stage_o = stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random lock/ready
// traffic, all checked each cycle against a count-based model.
module tb_reset_sequencer;

   localparam int LC = 4;
   localparam int GC = 2;
   localparam int TO = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       pll_locked = 1'b0;
   logic [2:0] ready_i = 3'b000;
   logic [2:0] reset_o;
   logic       done_o;
   logic       error_o;
   logic [2:0] state_o;
   logic [1:0] stage_o;

   int checks = 0;
   int errors = 0;

   reset_sequencer #(
      .LOCK_CYCLES(LC),
      .GAP_CYCLES (GC),
      .TIMEOUT    (TO)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .pll_locked(pll_locked),
      .ready_i   (ready_i),
      .reset_o   (reset_o),
      .done_o    (done_o),
      .error_o   (error_o),
      .state_o   (state_o),
      .stage_o   (stage_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, want, $time);
      end
   endtask

   // Model: lock history in two sample slots, progress as the number
   // of stages released plus a few flags.
   bit m_s1, m_s2;
   int m_rel, m_run, m_t;
   bit m_gap, m_flt, m_dn;
   bit started = 1'b0;

   always @(posedge clock) begin
      bit ls;
      ls = m_s2;
      if (reset) begin
         m_s1 = 0; m_s2 = 0;
         m_rel = 0; m_run = 0; m_t = 0;
         m_gap = 0; m_flt = 0; m_dn = 0;
      end else begin
         m_s2 = m_s1;
         m_s1 = pll_locked;
         if (m_flt) begin
         end else if (m_rel == 0) begin
            if (!ls) m_run = 0;
            else if (m_run + 1 == LC) begin
               m_rel = 1; m_run = 0; m_t = 0; m_gap = 0;
            end else m_run++;
         end else if (!ls) begin
            m_rel = 0; m_run = 0; m_t = 0; m_gap = 0; m_dn = 0;
         end else if (m_dn) begin
         end else if (m_gap) begin
            if (m_t == GC - 1) begin
               m_rel++; m_gap = 0; m_t = 0;
            end else m_t++;
         end else begin
            if (ready_i[m_rel-1]) begin
               m_t = 0;
               if (m_rel == 3) m_dn = 1;
               else m_gap = 1;
            end else if (m_t == TO - 1) m_flt = 1;
            else m_t++;
         end
      end
      started = 1'b1;
   end

   // Compare every output with the model on each falling edge.
   always @(negedge clock) begin
      if (started) begin
         int e_rst, e_st, e_stg;
         e_rst = m_flt ? 7 : (7 & ~((1 << m_rel) - 1));
         e_st  = m_flt ? 4 : (m_rel == 0) ? 0 : m_dn ? 3 : m_gap ? 2 : 1;
         e_stg = (m_rel == 0) ? 0 : m_rel - 1;
         check("model reset_o", int'(reset_o), e_rst);
         check("model done_o",  int'(done_o),  int'(m_dn && !m_flt));
         check("model error_o", int'(error_o), int'(m_flt));
         check("model state_o", int'(state_o), e_st);
         check("model stage_o", int'(stage_o), e_stg);
      end
   end

   task automatic do_reset(input bit pll);
      @(negedge clock);
      reset = 1'b1;
      ready_i = 3'b000;
      pll_locked = pll;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_rst(input logic [2:0] v, output int n);
      n = 0;
      while (reset_o !== v && n < 200) begin
         @(negedge clock);
         n++;
      end
   endtask

   initial begin
      int n;
      int mode;
      repeat (2) @(negedge clock);
      check("reset reset_o", int'(reset_o), 7);
      check("reset state_o", int'(state_o), 0);
      check("reset done_o", int'(done_o), 0);

      // Nominal sequence
      do_reset(1'b1);
      wait_rst(3'b110, n);
      check("lock_release_lat", n, 6);
      repeat (2) @(negedge clock);
      ready_i = 3'b001;
      wait_rst(3'b100, n);
      check("gap0_lat", n, 3);
      repeat (2) @(negedge clock);
      ready_i = 3'b011;
      wait_rst(3'b000, n);
      check("gap1_lat", n, 3);
      repeat (2) @(negedge clock);
      ready_i = 3'b111;
      @(negedge clock);
      check("run done_o", int'(done_o), 1);
      check("run state_o", int'(state_o), 3);
      ready_i = 3'b000;
      repeat (4) @(negedge clock);
      check("run ignores ready", int'(done_o), 1);

      // Lock loss in RUN, then re-lock
      pll_locked = 1'b0;
      wait_rst(3'b111, n);
      check("lockloss_lat", n, 3);
      check("lockloss state_o", int'(state_o), 0);
      pll_locked = 1'b1;
      wait_rst(3'b110, n);
      check("relock_lat", n, 6);

      // Lock glitch
      do_reset(1'b1);
      repeat (3) @(negedge clock);
      pll_locked = 1'b0;
      @(negedge clock);
      pll_locked = 1'b1;
      wait_rst(3'b110, n);
      check("glitch_release", n + 4, 10);

      // Timeout on stage 1
      do_reset(1'b1);
      wait_rst(3'b110, n);
      ready_i = 3'b001;
      wait_rst(3'b100, n);
      n = 0;
      while (state_o != 3'd4 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("timeout_lat", n, 8);
      check("fault reset_o", int'(reset_o), 7);
      check("fault error_o", int'(error_o), 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         pll_locked = ~pll_locked;
         ready_i = 3'($urandom);
      end
      @(negedge clock);
      check("fault held", int'(state_o), 4);

      // Ready on the timeout edge
      do_reset(1'b1);
      ready_i = 3'b000;
      pll_locked = 1'b1;
      wait_rst(3'b110, n);
      repeat (7) @(negedge clock);
      ready_i = 3'b001;
      @(negedge clock);
      check("last_cycle_ready", int'(state_o), 2);
      check("last_cycle_noerr", int'(error_o), 0);

      // Lock loss together with ready_i[2]
      do_reset(1'b1);
      wait_rst(3'b110, n);
      ready_i = 3'b001;
      wait_rst(3'b100, n);
      ready_i = 3'b011;
      wait_rst(3'b000, n);
      pll_locked = 1'b0;
      repeat (2) @(negedge clock);
      ready_i = 3'b111;
      @(negedge clock);
      check("loss_vs_ready", int'(state_o), 0);
      check("loss_vs_ready done", int'(done_o), 0);

      // Lock loss together with timeout
      do_reset(1'b1);
      wait_rst(3'b110, n);
      ready_i = 3'b001;
      wait_rst(3'b100, n);
      repeat (5) @(negedge clock);
      pll_locked = 1'b0;
      repeat (3) @(negedge clock);
      check("loss_vs_timeout", int'(state_o), 0);
      check("loss_vs_timeout err", int'(error_o), 0);

      // Random traffic
      do_reset(1'b1);
      mode = 0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clock);
         if (c % 64 == 0) begin
            n = $urandom_range(0, 99);
            mode = (n < 50) ? 0 : (n < 65) ? 1 : 2;
         end
         reset = ($urandom_range(0, 299) == 0);
         if (pll_locked) pll_locked = ($urandom_range(0, 149) != 0);
         else pll_locked = ($urandom_range(0, 3) == 0);
         case (mode)
            0: ready_i = 3'($urandom) & 3'($urandom);
            1: ready_i = 3'b000;
            default: ready_i = 3'b111;
         endcase
      end
      reset = 1'b0;
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
